// File: rtl/ecg_pkg.sv
// Shared types and decode helpers for the entropy-coding-group parser.
package ecg_pkg;

    localparam int unsigned MAX_PREFIX  = 8;
    localparam int unsigned MAX_BITSREQ = 9;
    localparam int unsigned BR_W        = 4;
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned SDEC_W      = MAX_BITSREQ + 1;
    localparam int unsigned SEXT_W      = MAX_BITSREQ + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_MAG,
        S_OUT,
        S_DONE
    } state_e;

    // Prefix codeword to bitsReq; transform mode remaps the short codewords.
    function automatic logic [BR_W-1:0] bits_req_map(
        input logic            xfm,
        input logic            first_ecg,
        input logic [BR_W-1:0] cw
    );
        logic [BR_W-1:0] br;
        br = cw + BR_W'(1);
        if (xfm) begin
            if (first_ecg) begin
                if (cw <= BR_W'(3)) begin
                    br = cw + BR_W'(2);
                end else if (cw == BR_W'(4)) begin
                    br = BR_W'(1);
                end
            end else begin
                if (cw == BR_W'(0)) begin
                    br = BR_W'(2);
                end else if (cw == BR_W'(1)) begin
                    br = BR_W'(1);
                end
            end
        end
        return br;
    endfunction

    // Raw field to signed sample, either sign-magnitude or two's complement.
    function automatic logic signed [SDEC_W-1:0] decode_sample(
        input logic [MAX_BITSREQ-1:0] raw,
        input logic [BR_W-1:0]        bits_req,
        input logic                   sm,
        input logic                   neg
    );
        logic signed [SEXT_W-1:0] v;
        logic        [SEXT_W-1:0] half;
        v    = $signed({2'b00, raw});
        half = SEXT_W'(1) << (bits_req - BR_W'(1));
        if (sm) begin
            if (neg) begin
                v = -v;
            end
        end else if ({2'b00, raw} >= half) begin
            v = v - $signed(half << 1);
        end
        return SDEC_W'(v);
    endfunction

endpackage

// File: rtl/ecg_sample_extract.sv
// Combinational magnitude/sign field extraction for one ECG from a bit window.
module ecg_sample_extract
    import ecg_pkg::*;
#(
    parameter int unsigned WIN_W       = 128,
    parameter int unsigned MAX_SAMPLES = 8,
    parameter int unsigned COEFF_W     = 10
) (
    input  logic [WIN_W-1:0]                   win,
    input  logic                               skip,
    input  logic [BR_W-1:0]                    plen,
    input  logic [BR_W-1:0]                    bits_req,
    input  logic [$clog2(MAX_SAMPLES+1)-1:0]   n_smp,
    input  logic                               sm,
    output logic [MAX_SAMPLES*COEFF_W-1:0]     coeff_c,
    output logic [MAX_SAMPLES-1:0]             nz_c,
    output logic [LEN_W-1:0]                   len_c
);

    localparam int unsigned SMP_W = $clog2(MAX_SAMPLES+1);

    logic [LEN_W-1:0] mag_base;
    logic [LEN_W-1:0] sign_base;

    always_comb begin
        mag_base  = LEN_W'(1) + LEN_W'(plen);
        sign_base = mag_base + LEN_W'(n_smp) * LEN_W'(bits_req);
    end

    // Sign bits are packed after the last magnitude, one per nonzero sample.
    always_comb begin
        logic [WIN_W-1:0]         shifted;
        logic [MAX_BITSREQ-1:0]   raw;
        logic [LEN_W-1:0]         n_sign;
        logic                     active;
        logic                     neg;
        logic signed [SDEC_W-1:0] val;
        coeff_c = '0;
        nz_c    = '0;
        shifted = '0;
        raw     = '0;
        n_sign  = '0;
        active  = 1'b0;
        neg     = 1'b0;
        val     = '0;
        for (int i = 0; i < MAX_SAMPLES; i++) begin
            shifted = win << (mag_base + LEN_W'(i) * LEN_W'(bits_req));
            raw     = shifted[WIN_W-1 -: MAX_BITSREQ] >> (BR_W'(MAX_BITSREQ) - bits_req);
            active  = !skip && (SMP_W'(i) < n_smp);
            shifted = win << (sign_base + n_sign);
            neg     = sm & shifted[WIN_W-1];
            val     = decode_sample(raw, bits_req, sm, neg);
            if (active && (val != '0)) begin
                nz_c[i]                       = 1'b1;
                coeff_c[i*COEFF_W +: COEFF_W] = COEFF_W'(val);
                n_sign                        = n_sign + LEN_W'(1);
            end
        end
        len_c = skip ? LEN_W'(1) : (sign_base + (sm ? n_sign : LEN_W'(0)));
    end

endmodule

// File: rtl/ecg_group_parser.sv
// Walks the ECGs of one component, emitting signed coefficients per group.
module ecg_group_parser
    import ecg_pkg::*;
#(
    parameter int unsigned NUM_ECG     = 4,
    parameter int unsigned MAX_SAMPLES = 8,
    parameter int unsigned COEFF_W     = 10,
    parameter int unsigned WIN_W       = 128,
    parameter int unsigned SM_ECG_CNT  = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               cfg_mode_xfm,
    input  logic [$clog2(NUM_ECG+1)-1:0]       cfg_num_ecg,
    input  logic [$clog2(MAX_SAMPLES+1)-1:0]   cfg_num_samples,
    input  logic [WIN_W-1:0]                   bits,
    input  logic                               bits_vld,
    output logic                               consume_vld,
    output logic [7:0]                         consume_len,
    output logic                               grp_vld,
    input  logic                               grp_rdy,
    output logic [$clog2(NUM_ECG)-1:0]         grp_idx,
    output logic                               grp_skip,
    output logic                               grp_last,
    output logic [MAX_SAMPLES*COEFF_W-1:0]     grp_coeff,
    output logic [MAX_SAMPLES-1:0]             grp_nz,
    output logic                               done
);

    localparam int unsigned IDX_W = $clog2(NUM_ECG);
    localparam int unsigned CNT_W = $clog2(NUM_ECG+1);
    localparam int unsigned SMP_W = $clog2(MAX_SAMPLES+1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               ecg_idx_q, ecg_idx_d;
    logic [CNT_W-1:0]               num_ecg_q, num_ecg_d;
    logic [SMP_W-1:0]               n_smp_q, n_smp_d;
    logic                           xfm_q, xfm_d;
    logic [WIN_W-1:0]               win_q, win_d;

    logic                           consume_vld_q, consume_vld_d;
    logic [LEN_W-1:0]               consume_len_q, consume_len_d;
    logic                           grp_vld_q, grp_vld_d;
    logic [IDX_W-1:0]               grp_idx_q, grp_idx_d;
    logic                           grp_skip_q, grp_skip_d;
    logic                           grp_last_q, grp_last_d;
    logic [MAX_SAMPLES*COEFF_W-1:0] grp_coeff_q, grp_coeff_d;
    logic [MAX_SAMPLES-1:0]         grp_nz_q, grp_nz_d;
    logic                           done_q, done_d;

    logic [WIN_W-1:0]               win_sel;
    logic                           skip_c;
    logic [BR_W-1:0]                prefix_c;
    logic [BR_W-1:0]                plen_c;
    logic [BR_W-1:0]                bits_req_c;
    logic                           sm_c;
    logic [MAX_SAMPLES*COEFF_W-1:0] coeff_c;
    logic [MAX_SAMPLES-1:0]         nz_c;
    logic [LEN_W-1:0]               len_c;

    // The live window feeds the decoder in HDR so consume_len is out one cycle
    // before the coefficients, giving upstream two cycles to shift.
    always_comb begin
        win_sel  = (state_q == S_HDR) ? bits : win_q;
        skip_c   = win_sel[WIN_W-1];
        prefix_c = '0;
        for (int k = 0; k < MAX_PREFIX; k++) begin
            if (win_sel[WIN_W-2-k] && (prefix_c == BR_W'(k))) begin
                prefix_c = prefix_c + BR_W'(1);
            end
        end
        plen_c     = (prefix_c == BR_W'(MAX_PREFIX)) ? BR_W'(MAX_PREFIX) : prefix_c + BR_W'(1);
        bits_req_c = bits_req_map(xfm_q, ecg_idx_q == '0, prefix_c);
        sm_c       = (32'(ecg_idx_q) < SM_ECG_CNT);
    end

    ecg_sample_extract #(
        .WIN_W       (WIN_W),
        .MAX_SAMPLES (MAX_SAMPLES),
        .COEFF_W     (COEFF_W)
    ) u_extract (
        .win      (win_sel),
        .skip     (skip_c),
        .plen     (plen_c),
        .bits_req (bits_req_c),
        .n_smp    (n_smp_q),
        .sm       (sm_c),
        .coeff_c  (coeff_c),
        .nz_c     (nz_c),
        .len_c    (len_c)
    );

    always_comb begin
        state_d       = state_q;
        ecg_idx_d     = ecg_idx_q;
        num_ecg_d     = num_ecg_q;
        n_smp_d       = n_smp_q;
        xfm_d         = xfm_q;
        win_d         = win_q;
        consume_vld_d = 1'b0;
        consume_len_d = consume_len_q;
        grp_vld_d     = grp_vld_q;
        grp_idx_d     = grp_idx_q;
        grp_skip_d    = grp_skip_q;
        grp_last_d    = grp_last_q;
        grp_coeff_d   = grp_coeff_q;
        grp_nz_d      = grp_nz_q;
        done_d        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    xfm_d     = cfg_mode_xfm;
                    ecg_idx_d = '0;
                    num_ecg_d = (cfg_num_ecg > CNT_W'(NUM_ECG)) ? CNT_W'(NUM_ECG) : cfg_num_ecg;
                    if (cfg_num_samples == '0) begin
                        n_smp_d = SMP_W'(1);
                    end else if (cfg_num_samples > SMP_W'(MAX_SAMPLES)) begin
                        n_smp_d = SMP_W'(MAX_SAMPLES);
                    end else begin
                        n_smp_d = cfg_num_samples;
                    end
                    if (cfg_num_ecg == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (bits_vld) begin
                    win_d         = bits;
                    consume_vld_d = 1'b1;
                    consume_len_d = len_c;
                    state_d       = S_MAG;
                end
            end
            S_MAG: begin
                grp_vld_d   = 1'b1;
                grp_idx_d   = ecg_idx_q;
                grp_skip_d  = skip_c;
                grp_coeff_d = coeff_c;
                grp_nz_d    = nz_c;
                grp_last_d  = (CNT_W'(ecg_idx_q) + CNT_W'(1)) == num_ecg_q;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (grp_rdy) begin
                    grp_vld_d = 1'b0;
                    if (grp_last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ecg_idx_d = ecg_idx_q + IDX_W'(1);
                        state_d   = S_HDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ecg_idx_q     <= '0;
            num_ecg_q     <= '0;
            n_smp_q       <= '0;
            xfm_q         <= 1'b0;
            win_q         <= '0;
            consume_vld_q <= 1'b0;
            consume_len_q <= '0;
            grp_vld_q     <= 1'b0;
            grp_idx_q     <= '0;
            grp_skip_q    <= 1'b0;
            grp_last_q    <= 1'b0;
            grp_coeff_q   <= '0;
            grp_nz_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ecg_idx_q     <= ecg_idx_d;
            num_ecg_q     <= num_ecg_d;
            n_smp_q       <= n_smp_d;
            xfm_q         <= xfm_d;
            win_q         <= win_d;
            consume_vld_q <= consume_vld_d;
            consume_len_q <= consume_len_d;
            grp_vld_q     <= grp_vld_d;
            grp_idx_q     <= grp_idx_d;
            grp_skip_q    <= grp_skip_d;
            grp_last_q    <= grp_last_d;
            grp_coeff_q   <= grp_coeff_d;
            grp_nz_q      <= grp_nz_d;
            done_q        <= done_d;
        end
    end

    assign consume_vld = consume_vld_q;
    assign consume_len = consume_len_q;
    assign grp_vld     = grp_vld_q;
    assign grp_idx     = grp_idx_q;
    assign grp_skip    = grp_skip_q;
    assign grp_last    = grp_last_q;
    assign grp_coeff   = grp_coeff_q;
    assign grp_nz      = grp_nz_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ecg_group_parser.sv
// Randomized bench for ecg_group_parser against a bit-serial reference reader.
module tb_ecg_group_parser;

    localparam int NE = 4;
    localparam int MS = 8;
    localparam int CW = 10;
    localparam int WW = 128;

    typedef struct {
        logic           skip;
        int             len;
        logic [MS*CW-1:0] coeff;
        logic [MS-1:0]  nz;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              cfg_mode_xfm;
    logic [2:0]        cfg_num_ecg;
    logic [3:0]        cfg_num_samples;
    logic [WW-1:0]     bits;
    logic              bits_vld;
    logic              consume_vld;
    logic [7:0]        consume_len;
    logic              grp_vld;
    logic              grp_rdy;
    logic [1:0]        grp_idx;
    logic              grp_skip;
    logic              grp_last;
    logic [MS*CW-1:0]  grp_coeff;
    logic [MS-1:0]     grp_nz;
    logic              done;

    always #5 clk = ~clk;

    ecg_group_parser #(
        .NUM_ECG(NE), .MAX_SAMPLES(MS), .COEFF_W(CW), .WIN_W(WW), .SM_ECG_CNT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode_xfm(cfg_mode_xfm),
        .cfg_num_ecg(cfg_num_ecg), .cfg_num_samples(cfg_num_samples),
        .bits(bits), .bits_vld(bits_vld), .consume_vld(consume_vld),
        .consume_len(consume_len), .grp_vld(grp_vld), .grp_rdy(grp_rdy),
        .grp_idx(grp_idx), .grp_skip(grp_skip), .grp_last(grp_last),
        .grp_coeff(grp_coeff), .grp_nz(grp_nz), .done(done)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [WW-1:0]    win_tab [NE];
    logic [7:0]       obs_len;
    logic [MS*CW-1:0] obs_coeff;
    logic [MS-1:0]    obs_nz;
    logic             obs_skip;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [WW-1:0] rand_bits();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Random window with a controlled header: sometimes skipped, prefix 0..8.
    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] w;
        int p;
        w = rand_bits();
        if ($urandom_range(0, 7) == 0) begin
            w[WW-1] = 1'b1;
        end else begin
            w[WW-1] = 1'b0;
            p = $urandom_range(0, 8);
            for (int k = 0; k < p; k++) w[WW-2-k] = 1'b1;
            if (p < 8) w[WW-2-p] = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] mkwin(input logic [WW-1:0] v, input int l);
        logic [WW-1:0] f;
        f = rand_bits();
        return (v << (WW - l)) | (f >> l);
    endfunction

    function automatic int rd(input logic [WW-1:0] w, input int p, input int l);
        int v = 0;
        for (int k = 0; k < l; k++) v = v * 2 + int'(w[WW-1-p-k]);
        return v;
    endfunction

    // Reads the group MSB-first exactly as the bitstream syntax lays it out.
    function automatic exp_t model(input logic [WW-1:0] w, input int idx, input bit xfm, input int n);
        exp_t e;
        int pos, pfx, br, val;
        int mags [MS];
        bit sm;
        e.skip  = w[WW-1];
        e.coeff = '0;
        e.nz    = '0;
        e.len   = 1;
        if (e.skip) return e;
        pos = 1;
        pfx = 0;
        while (pfx < 8 && w[WW-1-pos] == 1'b1) begin
            pfx++;
            pos++;
        end
        if (pfx < 8) pos++;
        if (!xfm) br = pfx + 1;
        else if (idx == 0) br = (pfx <= 3) ? pfx + 2 : (pfx == 4) ? 1 : pfx + 1;
        else br = (pfx == 0) ? 2 : (pfx == 1) ? 1 : pfx + 1;
        for (int i = 0; i < n; i++) begin
            mags[i] = rd(w, pos, br);
            pos += br;
        end
        sm = (idx < 3);
        for (int i = 0; i < n; i++) begin
            val = mags[i];
            if (sm) begin
                if (val != 0) begin
                    if (w[WW-1-pos]) val = -val;
                    pos++;
                end
            end else if (val > (1 << (br - 1)) - 1) begin
                val = val - (1 << br);
            end
            e.coeff[i*CW +: CW] = CW'(val);
            e.nz[i] = (val != 0);
        end
        e.len = pos;
        return e;
    endfunction

    task automatic chk_grp(input exp_t e, input int g, input bit last);
        chk("grp_vld", WW'(grp_vld), WW'(1));
        chk("grp_idx", WW'(grp_idx), WW'(g));
        chk("grp_skip", WW'(grp_skip), WW'(e.skip));
        chk("grp_last", WW'(grp_last), WW'(last));
        chk("grp_coeff", WW'(grp_coeff), WW'(e.coeff));
        chk("grp_nz", WW'(grp_nz), WW'(e.nz));
    endtask

    task automatic do_group(input int g, input bit xfm, input int n, input bit last, input int stall);
        exp_t e;
        e = model(win_tab[g], g, xfm, n);
        repeat ($urandom_range(0, 2)) begin
            bits     = rand_bits();
            bits_vld = 1'b0;
            @(negedge clk);
            chk("idle_cvld", WW'(consume_vld), WW'(0));
        end
        bits     = win_tab[g];
        bits_vld = 1'b1;
        @(negedge clk);
        chk("cvld", WW'(consume_vld), WW'(1));
        chk("clen", WW'(consume_len), WW'(e.len));
        chk("gvld_early", WW'(grp_vld), WW'(0));
        obs_len  = consume_len;
        bits_vld = 1'b0;
        bits     = rand_bits();
        @(negedge clk);
        chk("cvld_pulse", WW'(consume_vld), WW'(0));
        for (int s = 0; s < stall; s++) begin
            chk_grp(e, g, last);
            if (s == 0) begin
                start           = 1'b1;
                cfg_num_ecg     = 3'($urandom_range(0, 4));
                cfg_mode_xfm    = ~xfm;
                cfg_num_samples = 4'($urandom_range(0, 8));
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk_grp(e, g, last);
        obs_coeff = grp_coeff;
        obs_nz    = grp_nz;
        obs_skip  = grp_skip;
        grp_rdy   = 1'b1;
        @(negedge clk);
        grp_rdy = 1'b0;
        chk("gvld_drop", WW'(grp_vld), WW'(0));
        chk("done", WW'(done), WW'(last));
        if (last) begin
            @(negedge clk);
            chk("done_pulse", WW'(done), WW'(0));
        end
    endtask

    task automatic start_comp(input bit xfm, input int num, input int nsmp);
        cfg_mode_xfm    = xfm;
        cfg_num_ecg     = 3'(num);
        cfg_num_samples = 4'(nsmp);
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_comp(input bit xfm, input int num, input int nsmp, input int stall);
        int n_eff;
        n_eff = (nsmp == 0) ? 1 : nsmp;
        start_comp(xfm, num, nsmp);
        if (num == 0) begin
            chk("done_empty", WW'(done), WW'(1));
            @(negedge clk);
            chk("done_empty_clr", WW'(done), WW'(0));
        end else begin
            for (int g = 0; g < num; g++) begin
                do_group(g, xfm, n_eff, g == num - 1,
                         (stall < 0) ? int'($urandom_range(0, 3)) : stall);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        cfg_mode_xfm    = 1'b0;
        cfg_num_ecg     = '0;
        cfg_num_samples = '0;
        bits            = '0;
        bits_vld        = 1'b0;
        grp_rdy         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cvld", WW'(consume_vld), WW'(0));
        chk("rst_clen", WW'(consume_len), WW'(0));
        chk("rst_gvld", WW'(grp_vld), WW'(0));
        chk("rst_gidx", WW'(grp_idx), WW'(0));
        chk("rst_gskip", WW'(grp_skip), WW'(0));
        chk("rst_glast", WW'(grp_last), WW'(0));
        chk("rst_coeff", WW'(grp_coeff), WW'(0));
        chk("rst_nz", WW'(grp_nz), WW'(0));
        chk("rst_done", WW'(done), WW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        win_tab[0] = mkwin(WW'(1), 1);
        run_comp(1'b0, 1, 4, 0);
        chk("d_skip_len", WW'(obs_len), WW'(1));
        chk("d_skip_flag", WW'(obs_skip), WW'(1));
        chk("d_skip_coeff", WW'(obs_coeff), WW'(0));
        chk("d_skip_nz", WW'(obs_nz), WW'(0));

        win_tab[0] = mkwin(WW'(14'b01001001110101), 14);
        run_comp(1'b0, 1, 4, 0);
        chk("d_sm_len", WW'(obs_len), WW'(14));
        chk("d_sm_coeff", WW'(obs_coeff), WW'({40'd0, 10'h3FE, 10'h003, 10'h000, 10'h3FF}));
        chk("d_sm_nz", WW'(obs_nz), WW'(8'b0000_1101));

        for (int g = 0; g < 3; g++) win_tab[g] = rand_win();
        win_tab[3] = mkwin(WW'(10'b0110111011), 10);
        run_comp(1'b0, 4, 2, 1);
        chk("d_tc_len", WW'(obs_len), WW'(10));
        chk("d_tc_coeff", WW'(obs_coeff), WW'({60'd0, 10'h003, 10'h3FF}));

        win_tab[0] = mkwin(WW'(13'b0111101011001), 13);
        run_comp(1'b1, 1, 4, 0);
        chk("d_xfm_len", WW'(obs_len), WW'(13));
        chk("d_xfm_coeff", WW'(obs_coeff), WW'({40'd0, 10'h3FF, 10'h001, 10'h000, 10'h001}));

        win_tab[0] = mkwin(WW'(19'b0111111111111111111), 19);
        run_comp(1'b0, 1, 1, 0);
        chk("d_p8_len", WW'(obs_len), WW'(19));
        chk("d_p8_coeff", WW'(obs_coeff), WW'({70'd0, 10'h201}));

        for (int g = 0; g < NE; g++) win_tab[g] = rand_win();
        run_comp(1'b0, 2, 3, 5);

        // Reset while the first group is in MAG.
        win_tab[0] = rand_win();
        start_comp(1'b0, 2, 4);
        bits     = win_tab[0];
        bits_vld = 1'b1;
        @(negedge clk);
        chk("mag_cvld", WW'(consume_vld), WW'(1));
        rst_n = 1'b0;
        #1;
        chk("mrst_cvld", WW'(consume_vld), WW'(0));
        chk("mrst_gvld", WW'(grp_vld), WW'(0));
        chk("mrst_clen", WW'(consume_len), WW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_cvld", WW'(consume_vld), WW'(0));
            chk("post_rst_gvld", WW'(grp_vld), WW'(0));
        end
        bits_vld = 1'b0;

        repeat (60) begin
            for (int g = 0; g < NE; g++) win_tab[g] = rand_win();
            run_comp(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 8), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
